// File: rtl/vga_timing_pkg.sv
// ============================================================================
// vga_timing_pkg : 640x480@60 default timing constants and RGB332->RGB444 helper
// Revision 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  typedef logic [7:0]  rgb332_t;
  typedef logic [11:0] rgb444_t;

  // Bit replication keeps full-scale codes at full scale (3'b111 -> 4'hF).
  function automatic rgb444_t rgb332_to_444(input rgb332_t c);
    return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// vga_axis_counter : enabled wrap counter with active-area and sync-window flags
// Revision 1.0
// ============================================================================
`default_nettype none

module vga_axis_counter #(
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] count,
  output logic       wrap,
  output logic       in_active,
  output logic       in_sync
);

  logic [9:0]  count_q;
  logic [9:0]  count_d;
  logic [10:0] count_ext;

  always_comb begin
    wrap    = en && (count_q == 10'(TOTAL - 1));
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // 11-bit compares so an end bound of 1024 stays representable.
  assign count_ext = {1'b0, count_q};
  assign count     = count_q;
  assign in_active = count_ext < 11'(ACTIVE);
  assign in_sync   = (count_ext >= 11'(SYNC_START)) && (count_ext < 11'(SYNC_END));

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen : pixel-tick divider, raster counters, colour/sync output stage
// Revision 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rgb_in,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic       pix_valid,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W  = $clog2(CLK_DIV);

  if (CLK_DIV < 2 || H_TOT > 1024 || V_TOT > 1024 || V_ACTIVE > 512) begin : g_param_check
    $error("vga_timing_gen: timing parameters out of range");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;
  logic [9:0]       h_cnt, v_cnt;
  logic             h_wrap, h_act, h_sync_w;
  logic             v_wrap, v_act, v_sync_w;
  rgb332_t          rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_tick_q, frame_tick_d;
  rgb444_t          rgb444;

  assign tick = (div_cnt_q == DIV_W'(CLK_DIV - 1));

  vga_axis_counter #(
    .TOTAL      (H_TOT),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (tick),
    .count     (h_cnt),
    .wrap      (h_wrap),
    .in_active (h_act),
    .in_sync   (h_sync_w)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOT),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (h_wrap),
    .count     (v_cnt),
    .wrap      (v_wrap),
    .in_active (v_act),
    .in_sync   (v_sync_w)
  );

  assign pix_valid = h_act && v_act;
  assign pix_x     = pix_valid ? h_cnt : '0;
  assign pix_y     = pix_valid ? v_cnt[8:0] : '0;

  // Output stage samples on tick so colour and syncs share one tick of latency.
  always_comb begin
    div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
    rgb_d        = rgb_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    if (tick) begin
      rgb_d   = pix_valid ? rgb_in : 8'h00;
      hsync_d = ~h_sync_w;
      vsync_d = ~v_sync_w;
    end
    frame_tick_d = h_wrap && !v_wrap && (v_cnt == 10'(V_ACTIVE - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      rgb_q        <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign rgb444     = rgb332_to_444(rgb_q);
  assign vga_r      = rgb444[11:8];
  assign vga_g      = rgb444[7:4];
  assign vga_b      = rgb444[3:0];
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// tb_vga_timing_gen : reduced-raster bench with a tick-count reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  localparam int CLK_DIV = 4;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLKS = HT * VT * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rgb_in = 8'h00;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic       pix_valid;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       hsync, vsync, frame_tick;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rgb_in     (rgb_in),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_valid  (pix_valid),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int c = 0;          // rising edges seen since reset release
  int ft_seen = 0;
  logic hold = 1'b1;
  logic ff_mode = 1'b0;
  logic [3:0] e_r, e_g, e_b;
  logic e_hs, e_vs, e_ft;

  // Linear rescale of an n-bit level onto 0..15.
  function automatic logic [3:0] scale3(int v3);
    return 4'((v3 * 15 + 3) / 7);
  endfunction
  function automatic logic [3:0] scale2(int v2);
    return 4'(v2 * 5);
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    c = 0;
    e_r = 4'h0; e_g = 4'h0; e_b = 4'h0;
    e_hs = 1'b1; e_vs = 1'b1; e_ft = 1'b0;
  endtask

  task automatic check_all();
    int k, h, v;
    logic ev;
    k  = c / CLK_DIV;
    h  = k % HT;
    v  = (k / HT) % VT;
    ev = (h < HA) && (v < VA);
    chk("pix_valid", 12'(pix_valid), 12'(ev));
    chk("pix_x", 12'(pix_x), ev ? 12'(h) : 12'(0));
    chk("pix_y", 12'(pix_y), ev ? 12'(v) : 12'(0));
    chk("vga_r", 12'(vga_r), 12'(e_r));
    chk("vga_g", 12'(vga_g), 12'(e_g));
    chk("vga_b", 12'(vga_b), 12'(e_b));
    chk("hsync", 12'(hsync), 12'(e_hs));
    chk("vsync", 12'(vsync), 12'(e_vs));
    chk("frame_tick", 12'(frame_tick), 12'(e_ft));
    if (frame_tick === 1'b1) ft_seen++;
  endtask

  // One clock: advance the model at the edge, compare at the falling edge, re-drive rgb_in.
  task automatic step();
    int k, p, h, v;
    @(posedge clk);
    if (rst_n) begin
      c++;
      e_ft = 1'b0;
      if (c % CLK_DIV == 0) begin
        k = c / CLK_DIV;
        p = k - 1;
        h = p % HT;
        v = (p / HT) % VT;
        if (h < HA && v < VA) begin
          e_r = scale3(int'(rgb_in[7:5]));
          e_g = scale3(int'(rgb_in[4:2]));
          e_b = scale2(int'(rgb_in[1:0]));
        end else begin
          e_r = 4'h0; e_g = 4'h0; e_b = 4'h0;
        end
        e_hs = !(h >= HA + HF && h < HA + HF + HS);
        e_vs = !(v >= VA + VF && v < VA + VF + VS);
        e_ft = (k % HT == 0) && ((k / HT) % VT == VA);
      end
    end
    @(negedge clk);
    check_all();
    if (!hold) rgb_in = ff_mode ? 8'hFF : 8'($urandom);
  endtask

  initial begin
    int k;
    logic found;
    model_reset();
    rgb_in = 8'b111_000_00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    repeat (4) step();
    chk("dir_red_r", 12'(vga_r), 12'h00F);
    chk("dir_red_g", 12'(vga_g), 12'h000);
    chk("dir_red_b", 12'(vga_b), 12'h000);
    rgb_in = 8'b000_111_10;
    repeat (4) step();
    chk("dir_grn_r", 12'(vga_r), 12'h000);
    chk("dir_grn_g", 12'(vga_g), 12'h00F);
    chk("dir_grn_b", 12'(vga_b), 12'h00A);
    hold = 1'b0;

    repeat (2 * FRAME_CLKS) step();

    ff_mode = 1'b1;
    ft_seen = 0;
    repeat (FRAME_CLKS) step();
    chk("frame_tick_per_frame", 12'(ft_seen), 12'd1);
    ff_mode = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
      step();
      k = c / CLK_DIV;
      if (k % HT == 10 && (k / HT) % VT == 5) found = 1'b1;
    end
    chk("reset_point_reached", 12'(found), 12'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (5) step();
    rst_n = 1'b1;
    repeat (HT * CLK_DIV * 3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
